uart_tx_fifo: RTL

//  Memory-mapped UART transmitter on the core data bus at uart_base_addr..uart_top_addr.
//  - Buffers bytes written by the core in a small FIFO.
//  - Serialises them 8N1 (LSB first) on uart_tx, timed by clks_per_bit from the configure package.
//  - Sits downstream of the configure package and the bus address decoder; drives the board TX pin.

---
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: bus writes fill a byte FIFO drained onto an 8N1 serial line.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1 frames).
module uart_tx_fifo #(
  parameter int unsigned clks_per_bit = 216,
  parameter int unsigned fifo_depth   = 2
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        uart_valid,
  input  logic        uart_instr,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_wstrb,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  output logic        uart_tx
);
  localparam int unsigned Entries = 1 << fifo_depth;
  localparam int unsigned CntW = (clks_per_bit > 0) ? $clog2(clks_per_bit + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(clks_per_bit);
  localparam logic [fifo_depth:0] CountFull = (fifo_depth + 1)'(Entries);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd3;
`endif

  logic [7:0]            mem_q [Entries];
  logic [fifo_depth-1:0] wptr_q, rptr_q;
  logic [fifo_depth:0]   count_q, count_d;
  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  ready_q;
  logic [31:0]           rdata_q, rdata_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic full, empty, busy, req, hit, is_write, push_req, push, pop, ack, bit_done;
  logic unused_bits;

  assign unused_bits = ^{uart_addr[31:8], uart_wdata[31:8]};

  assign full     = (count_q == CountFull);
  assign empty    = (count_q == '0);
  assign busy     = (state_q != StIdle);
  // Master holds valid through the ack cycle; ignore it then so one request acks once.
  assign req      = uart_valid && !ready_q;
  assign hit      = !uart_instr && (uart_addr[7:0] == 8'h00);
  assign is_write = |uart_wstrb;
  assign push_req = req && hit && uart_wstrb[0];
  assign pop      = (state_q == StIdle) && !empty;
  assign push     = push_req && (!full || pop);
  assign ack      = req && (!push_req || push);
  assign bit_done = (cnt_q == CntMax);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (fifo_depth + 1)'(1);
      2'b01:   count_d = count_q - (fifo_depth + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    if (ack && hit && !is_write) rdata_d = {29'b0, full, empty, busy};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (!empty) begin
          shift_d = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
          par_d   = ^mem_q[rptr_q];
`endif
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d  = 1'b0;
        cnt_d = bit_done ? '0 : cnt_q + CntW'(1);
        if (bit_done) state_d = StData;
      end
      StData: begin
        tx_d  = shift_q[0];
        cnt_d = bit_done ? '0 : cnt_q + CntW'(1);
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        tx_d  = par_q;
        cnt_d = bit_done ? '0 : cnt_q + CntW'(1);
        if (bit_done) state_d = StStop;
      end
`endif
      StStop: begin
        cnt_d = bit_done ? '0 : cnt_q + CntW'(1);
        if (bit_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage is not reset; occupancy and pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= uart_wdata[7:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      rdata_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      if (push) wptr_q <= wptr_q + fifo_depth'(1);
      if (pop)  rptr_q <= rptr_q + fifo_depth'(1);
      count_q <= count_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ack;
      rdata_q <= rdata_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign uart_tx    = tx_q;
  assign uart_ready = ready_q;
  assign uart_rdata = rdata_q;

endmodule
